// File: rtl/fg_prog_pkg.sv
// Shared types and helpers for the floating-gate programming sequencer.
// Holds the mode/state encodings and the one-hot address decoder.
package fg_prog_pkg;

    typedef enum logic [1:0] {
        MODE_TUNNEL = 2'd0,
        MODE_INJECT = 2'd1,
        MODE_READ   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_TAIL   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam int DEC_W = 32;

    // Callers size-cast the result down to their select width.
    function automatic logic [DEC_W-1:0] decode_onehot(
        input  logic [31:0] idx,
        input  logic [31:0] n,
        output logic        oor
    );
        oor = (idx >= n);
        decode_onehot = oor ? '0 : (DEC_W'(1) << idx);
    endfunction

endpackage

// File: rtl/fg_pulse_timer.sv
// Loadable down-counter with a zero flag; times the settle, pulse and gap intervals.
// Loading L-1 on entry to a state makes zero rise in the L-th cycle of that state.
module fg_pulse_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Programming sequencer for floating-gate indirect switch islands: latches a target
// command, drives one-hot mux selects and emits counted VTUN/inject/read pulses.
module fg_prog_sequencer
    import fg_prog_pkg::*;
#(
    parameter int N_ISL  = 2,
    parameter int N_ROW  = 4,
    parameter int N_COL  = 2,
    parameter int PW_W   = 8,
    parameter int PC_W   = 6,
    parameter int SETTLE = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [$clog2(N_ISL)-1:0] cmd_island,
    input  logic [$clog2(N_ROW)-1:0] cmd_row,
    input  logic [$clog2(N_COL)-1:0] cmd_col,
    input  logic                     cmd_dir,
    input  logic [1:0]               cmd_mode,
    input  logic [PC_W-1:0]          cmd_npulse,
    input  logic [PW_W-1:0]          cmd_pwidth,
    output logic [N_ISL-1:0]         isl_sel,
    output logic [N_ROW-1:0]         row_sel,
    output logic [N_COL-1:0]         col_sel,
    output logic                     vtun_en,
    output logic                     vinj_en,
    output logic                     meas_strobe,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [PW_W-1:0] SETTLE_M1 = PW_W'(SETTLE - 1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [N_ISL-1:0]  isl_sel_q, isl_sel_d, isl_dec;
    logic [N_ROW-1:0]  row_sel_q, row_sel_d, row_dec;
    logic [N_COL-1:0]  col_sel_q, col_sel_d, col_dec;
    logic              isl_oor, row_oor, col_oor;
    logic [PC_W-1:0]   rem_q, rem_d;
    logic [PW_W-1:0]   wid_q, wid_d, pls_q, pls_d, cmd_wid;
    logic              vtun_q, vtun_d, vinj_q, vinj_d, meas_q, meas_d;
    logic              done_q, done_d, err_q, err_d;
    logic              tmr_load, tmr_zero;
    logic [PW_W-1:0]   tmr_val;

    fg_pulse_timer #(.W(PW_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        isl_sel_d = isl_sel_q;
        row_sel_d = row_sel_q;
        col_sel_d = col_sel_q;
        rem_d     = rem_q;
        wid_d     = wid_q;
        pls_d     = pls_q;
        vtun_d    = vtun_q;
        vinj_d    = vinj_q;
        meas_d    = meas_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        isl_dec   = N_ISL'(decode_onehot(32'(cmd_island), N_ISL, isl_oor));
        row_dec   = N_ROW'(decode_onehot(32'(cmd_row), N_ROW, row_oor));
        col_dec   = N_COL'(decode_onehot(32'(cmd_col), N_COL, col_oor));
        // Stored as interval-minus-one so it loads straight into the timer.
        cmd_wid   = (cmd_pwidth == '0) ? '0 : cmd_pwidth - PW_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mode_d = mode_e'(cmd_mode);
                    rem_d  = cmd_npulse;
                    wid_d  = cmd_wid;
                    pls_d  = (mode_e'(cmd_mode) == MODE_READ) ? '0 : cmd_wid;
                    if (isl_oor || row_oor || col_oor || mode_e'(cmd_mode) == MODE_RSVD) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = ST_SELECT;
                        isl_sel_d = isl_dec;
                        row_sel_d = cmd_dir ? '1 : row_dec;
                        col_sel_d = cmd_dir ? col_dec : '1;
                        tmr_load  = 1'b1;
                        tmr_val   = SETTLE_M1;
                    end
                end
            end
            ST_SELECT, ST_GAP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (state_q == ST_SELECT && rem_q == '0) begin
                        state_d = ST_TAIL;
                        tmr_val = SETTLE_M1;
                    end else begin
                        state_d = ST_PULSE;
                        tmr_val = pls_q;
                        vtun_d  = (mode_q == MODE_TUNNEL);
                        vinj_d  = (mode_q == MODE_INJECT);
                        meas_d  = (mode_q == MODE_READ);
                    end
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    vtun_d   = 1'b0;
                    vinj_d   = 1'b0;
                    meas_d   = 1'b0;
                    rem_d    = rem_q - PC_W'(1);
                    tmr_load = 1'b1;
                    // The gap after the final pulse is skipped.
                    if (rem_q == PC_W'(1)) begin
                        state_d = ST_TAIL;
                        tmr_val = SETTLE_M1;
                    end else begin
                        state_d = ST_GAP;
                        tmr_val = wid_q;
                    end
                end
            end
            ST_TAIL: begin
                if (tmr_zero) begin
                    state_d   = ST_DONE;
                    isl_sel_d = '0;
                    row_sel_d = '0;
                    col_sel_d = '0;
                    done_d    = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_TUNNEL;
            isl_sel_q <= '0;
            row_sel_q <= '0;
            col_sel_q <= '0;
            rem_q     <= '0;
            wid_q     <= '0;
            pls_q     <= '0;
            vtun_q    <= 1'b0;
            vinj_q    <= 1'b0;
            meas_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            isl_sel_q <= isl_sel_d;
            row_sel_q <= row_sel_d;
            col_sel_q <= col_sel_d;
            rem_q     <= rem_d;
            wid_q     <= wid_d;
            pls_q     <= pls_d;
            vtun_q    <= vtun_d;
            vinj_q    <= vinj_d;
            meas_q    <= meas_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign isl_sel     = isl_sel_q;
    assign row_sel     = row_sel_q;
    assign col_sel     = col_sel_q;
    assign vtun_en     = vtun_q;
    assign vinj_en     = vinj_q;
    assign meas_strobe = meas_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
